bram_fifo_ctrl: RTL
===================

Name: bram_fifo_ctrl

Overview:
Synchronous FIFO controller that uses an external wbDPBRAM instance as its storage. Port A is driven write-only and port B read-only. The block exposes valid/ready push and pop interfaces plus occupancy status. It sits directly upstream of the dual-port RAM and owns its enables, addresses and write data. Pop data is first-word-fall-through from a 2-entry output buffer, which hides the RAM's 1-cycle read latency and sustains 1 word/cycle.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
ADDR_WIDTH, 10, RAM address width; RAM depth DEPTH = 2^ADDR_WIDTH.

Ports:
i_clk  in  1  single clock, shared with the RAM.
i_reset_n  in  1  synchronous, active-low reset.
i_wr_valid  in  1  push request.
o_wr_ready  out  1  push accepted when i_wr_valid && o_wr_ready at a rising edge.
i_wr_data  in  DATA_WIDTH  push data.
o_rd_valid  out  1  head word available.
i_rd_ready  in  1  pop when o_rd_valid && i_rd_ready at a rising edge.
o_rd_data  out  DATA_WIDTH  head word.
o_count  out  ADDR_WIDTH+2  total words held (RAM + in-flight read + output buffer).
o_full  out  1  equals !o_wr_ready.
o_empty  out  1  equals !o_rd_valid.
o_enA  out  1  RAM port A enable.
o_weA  out  1  RAM port A write enable.
o_addrA  out  ADDR_WIDTH  RAM port A address (write pointer).
o_dinA  out  DATA_WIDTH  RAM port A data; equals i_wr_data.
o_enB  out  1  RAM port B enable.
o_weB  out  1  RAM port B write enable; tied 0.
o_addrB  out  ADDR_WIDTH  RAM port B address (read pointer).
i_doutB  in  DATA_WIDTH  RAM port B read data, valid the cycle after a port B read.

Behaviour:
- Reset (i_reset_n low at an edge) clears:
  - wr_ptr, rd_ptr, mem_count, inflight and buffer occupancy;
  - o_rd_valid=0, o_count=0, o_empty=1, o_full=0, o_wr_ready=1;
  - o_rd_data=0.
- While i_reset_n is low: o_enA=o_weA=o_enB=0 (combinational).
- Push:
  - o_wr_ready = (mem_count < DEPTH).
  - o_enA = o_weA = i_wr_valid && o_wr_ready.
  - On accept, wr_ptr increments and wraps from DEPTH-1 to 0.
- Read issue:
  - Condition: mem_count > 0 && (buf_occ + inflight - pop) < 2, where pop = o_rd_valid && i_rd_ready.
  - When it holds, o_enB=1 and rd_ptr increments (wrapping); inflight is set for the next cycle, otherwise cleared.
- Capture: when inflight=1, i_doutB is written to the buffer tail at the edge.
  - If the buffer is empty, or holds 1 word that is popped that cycle, i_doutB becomes the head directly.
- mem_count update: +1 on push, -1 on issue, unchanged when both occur.
- o_count = mem_count + inflight + buf_occ; maximum DEPTH+2.
- No address collision is possible: reads target only occupied slots and writes only free slots.
- Latency:
  - Push accepted into an empty FIFO at edge E0: the read issues in the following cycle, and o_rd_valid rises after E2.
  - Steady state: one push and one pop per cycle indefinitely.
- Ordering: strict FIFO order, including across pointer wrap.
- Simultaneous push and pop:
  - When full, a push only succeeds if a slot frees via issue in a later cycle; o_wr_ready is not combinationally dependent on i_rd_ready.
  - When empty, no pop occurs because o_rd_valid=0.
- o_rd_data is held stable while o_rd_valid && !i_rd_ready.
- Reset mid-operation discards all contents. Any port B read in flight is ignored.

Optional Feature:
Macro BRAM_FIFO_CTRL_FLUSH_EN.
- Defined:
  - Adds input i_flush (1 bit).
  - i_flush=1 at an edge acts exactly like reset on pointers, counts, inflight and buffer.
  - During a flush cycle: o_wr_ready=0, o_enA=0, o_enB=0, and pop is ignored.
  - Flushing while a read is in flight discards the returned data.
  - Normal operation resumes the next cycle.
- Undefined: no i_flush port; contents are cleared only by reset.

Test Plan:
(DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16)
- Reset: hold i_reset_n=0 for 3 cycles with i_wr_valid=1 -> o_enA=0, o_enB=0, o_count=0, o_empty=1, o_wr_ready=1.
- Single word: push 0xA5 at E0 into an empty FIFO -> o_rd_valid=1 with o_rd_data=0xA5 after E2; o_count=1; pop -> o_empty=1, o_count=0.
- Fill: i_rd_ready=0, push 0x00,0x01,... continuously -> exactly 18 accepted (0x00..0x11); o_full=1, o_count=18. Then drain -> output 0x00..0x11 in order, and o_wr_ready rises the cycle after the first RAM issue.
- Streaming wrap: i_wr_valid=i_rd_ready=1 for 40 cycles with incrementing data -> after startup, one pop per cycle, order preserved, pointers wrap twice, o_count stays ≤3.
- Reset mid-operation: with 10 words stored and a read in flight, assert reset for 1 cycle -> o_count=0, o_rd_valid=0; the next push of 0x5C is the next word popped.
- Flush (BRAM_FIFO_CTRL_FLUSH_EN): with 8 words stored, pulse i_flush while pushing 0xEE -> 0xEE is dropped; o_count=0 next cycle; subsequent push of 0x11 pops as 0x11.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO controller over an external dual-port BRAM with a 2-entry FWFT output buffer
// Optional flush input enabled by defining BRAM_FIFO_CTRL_FLUSH_EN.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
`ifdef BRAM_FIFO_CTRL_FLUSH_EN
  input  logic                  i_flush,
`endif
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH+1:0] o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_enA,
  output logic                  o_weA,
  output logic [ADDR_WIDTH-1:0] o_addrA,
  output logic [DATA_WIDTH-1:0] o_dinA,
  output logic                  o_enB,
  output logic                  o_weB,
  output logic [ADDR_WIDTH-1:0] o_addrB,
  input  logic [DATA_WIDTH-1:0] i_doutB
);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic                  r_inflight;
  logic [1:0]            r_buf_occ;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic       w_flush;
  logic       w_wr_ready;
  logic       w_push;
  logic       w_pop;
  logic       w_issue;
  logic [1:0] w_after_pop;
  logic [2:0] w_pending;

`ifdef BRAM_FIFO_CTRL_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // mem_count never exceeds DEPTH, so its MSB alone signals a full RAM
  assign w_wr_ready  = !r_mem_count[ADDR_WIDTH] && !w_flush;
  assign w_push      = i_reset_n && i_wr_valid && w_wr_ready;
  assign w_pop       = (r_buf_occ != 2'd0) && i_rd_ready && !w_flush;
  assign w_after_pop = r_buf_occ - {1'b0, w_pop};
  assign w_pending   = {1'b0, r_buf_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = i_reset_n && !w_flush && (r_mem_count != '0) && (w_pending < 3'd2);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || w_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_inflight  <= 1'b0;
      r_buf_occ   <= 2'd0;
      r_buf0      <= '0;
      r_buf1      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_mem_count <= r_mem_count + 1'b1;
        2'b01:   r_mem_count <= r_mem_count - 1'b1;
        default: r_mem_count <= r_mem_count;
      endcase
      r_inflight <= w_issue;
      if (w_pop) r_buf0 <= r_buf1;
      // returning RAM data lands in the first slot left free after this cycle's pop
      if (r_inflight) begin
        if (w_after_pop == 2'd0) r_buf0 <= i_doutB;
        else                     r_buf1 <= i_doutB;
      end
      r_buf_occ <= w_after_pop + {1'b0, r_inflight};
    end
  end

  assign o_wr_ready = w_wr_ready;
  assign o_full     = !w_wr_ready;
  assign o_rd_valid = (r_buf_occ != 2'd0);
  assign o_empty    = (r_buf_occ == 2'd0);
  assign o_rd_data  = r_buf0;
  assign o_count    = {1'b0, r_mem_count} + {{(ADDR_WIDTH+1){1'b0}}, r_inflight} + {{ADDR_WIDTH{1'b0}}, r_buf_occ};
  assign o_enA      = w_push;
  assign o_weA      = w_push;
  assign o_addrA    = r_wr_ptr;
  assign o_dinA     = i_wr_data;
  assign o_enB      = w_issue;
  assign o_weB      = 1'b0;
  assign o_addrB    = r_rd_ptr;

endmodule
